// File: rtl/uart_cmd_framer.sv
// UART command/response framer: 8N1 serial core plus an RX command assembler and a TX response
// serialiser. CLKS_PER_BIT sets the bit period in clk cycles.
module uart_cmd_framer #(
  parameter int CMD_BYTES    = 2,
  parameter int RESP_BYTES   = 1,
  parameter int TIMEOUT_CYC  = 65536,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RX,
  output logic                    TX,
  input  logic                    clr_cmd_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  output logic                    frame_err,
  output logic                    overrun,
  input  logic                    send_resp,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    tx_busy,
  output logic                    resp_sent
);
  localparam int CW     = 8*CMD_BYTES;
  localparam int RW     = 8*RESP_BYTES;
  localparam int CNT_W  = $clog2(CMD_BYTES+1);
  localparam int BCNT_W = $clog2(RESP_BYTES+1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT+1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT-1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT/2);
  localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT_CYC-1);

  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_HOLD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_GUARD, TX_WAIT} tx_state_t;

  logic              urx_meta_q, urx_sync_q, urx_busy_q, urx_rdy_q;
  logic [BAUD_W-1:0] urx_baud_q;
  logic [3:0]        urx_bit_q;
  logic [7:0]        urx_shift_q;
  logic              utx_busy_q, utx_done_q;
  logic [BAUD_W-1:0] utx_baud_q;
  logic [3:0]        utx_bit_q;
  logic [8:0]        utx_shift_q;

  rx_state_t         rx_state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       timer_q;
  logic [CW-1:0]     cmd_q;
  logic              cmd_rdy_q, frame_err_q, overrun_q, clr_rdy_q;
  logic              byte_ok;
  logic [CW-1:0]     cmd_shift;

  tx_state_t         tx_state_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [RW-1:0]     shreg_q;
  logic [7:0]        tx_data_q;
  logic              trmt_q, tx_busy_q, resp_sent_q;

  // Serial receiver: samples mid-bit; rdy holds until acknowledged or a new start bit arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urx_meta_q  <= 1'b1;
      urx_sync_q  <= 1'b1;
      urx_busy_q  <= 1'b0;
      urx_rdy_q   <= 1'b0;
      urx_baud_q  <= '0;
      urx_bit_q   <= '0;
      urx_shift_q <= '0;
    end else begin
      urx_meta_q <= RX;
      urx_sync_q <= urx_meta_q;
      if (clr_rdy_q) urx_rdy_q <= 1'b0;
      if (!urx_busy_q) begin
        if (!urx_sync_q) begin
          urx_busy_q <= 1'b1;
          urx_rdy_q  <= 1'b0;
          urx_baud_q <= BAUD_HALF;
          urx_bit_q  <= '0;
        end
      end else if (urx_baud_q == '0) begin
        urx_baud_q <= BAUD_LAST;
        urx_bit_q  <= urx_bit_q + 4'd1;
        if (urx_bit_q != 4'd0 && urx_bit_q != 4'd9) urx_shift_q <= {urx_sync_q, urx_shift_q[7:1]};
        if (urx_bit_q == 4'd9) begin
          urx_busy_q <= 1'b0;
          urx_rdy_q  <= 1'b1;
        end
      end else begin
        urx_baud_q <= urx_baud_q - 1'b1;
      end
    end
  end

  // Serial transmitter: start bit in the LSB, ones shift in behind the data to form the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      utx_busy_q  <= 1'b0;
      utx_done_q  <= 1'b0;
      utx_baud_q  <= '0;
      utx_bit_q   <= '0;
      utx_shift_q <= '1;
    end else if (trmt_q) begin
      utx_busy_q  <= 1'b1;
      utx_done_q  <= 1'b0;
      utx_baud_q  <= BAUD_LAST;
      utx_bit_q   <= '0;
      utx_shift_q <= {tx_data_q, 1'b0};
    end else if (utx_busy_q) begin
      if (utx_baud_q == '0) begin
        utx_baud_q  <= BAUD_LAST;
        utx_bit_q   <= utx_bit_q + 4'd1;
        utx_shift_q <= {1'b1, utx_shift_q[8:1]};
        if (utx_bit_q == 4'd9) begin
          utx_busy_q <= 1'b0;
          utx_done_q <= 1'b1;
        end
      end else begin
        utx_baud_q <= utx_baud_q - 1'b1;
      end
    end
  end

  assign TX = utx_busy_q ? utx_shift_q[0] : 1'b1;

  // The cycle after an acknowledge is locked out so a byte is not taken twice while rdy falls.
  assign byte_ok   = urx_rdy_q & ~clr_rdy_q;
  assign cmd_shift = (cmd_q << 8) | CW'(urx_shift_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      clr_rdy_q   <= 1'b0;
    end else begin
      clr_rdy_q   <= byte_ok;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (byte_ok) begin
          cmd_q   <= cmd_shift;
          cnt_q   <= CNT_W'(1);
          timer_q <= '0;
          if (CMD_BYTES == 1) begin
            rx_state_q <= RX_HOLD;
            cmd_rdy_q  <= 1'b1;
          end else begin
            rx_state_q <= RX_COLLECT;
          end
        end
        RX_COLLECT: begin
          if (clr_cmd_rdy) begin
            cnt_q      <= '0;
            rx_state_q <= RX_IDLE;
          end else if (byte_ok) begin
            cmd_q   <= cmd_shift;
            cnt_q   <= cnt_q + 1'b1;
            timer_q <= '0;
            if (cnt_q == CNT_W'(CMD_BYTES-1)) begin
              rx_state_q <= RX_HOLD;
              cmd_rdy_q  <= 1'b1;
            end
          end else if (TIMEOUT_CYC != 0 && timer_q == TMO_LAST) begin
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
            rx_state_q  <= RX_IDLE;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + 32'd1;
          end
        end
        RX_HOLD: begin
          if (byte_ok) overrun_q <= 1'b1;
          if (clr_cmd_rdy) begin
            cmd_rdy_q  <= 1'b0;
            cnt_q      <= '0;
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // TX_GUARD skips the cycle where the previous byte's tx_done is still visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: if (send_resp) begin
          shreg_q    <= resp;
          bcnt_q     <= '0;
          tx_busy_q  <= 1'b1;
          tx_state_q <= TX_LOAD;
        end
        TX_LOAD: begin
          trmt_q     <= 1'b1;
          tx_data_q  <= shreg_q[RW-1 -: 8];
          tx_state_q <= TX_GUARD;
        end
        TX_GUARD: tx_state_q <= TX_WAIT;
        TX_WAIT: if (utx_done_q) begin
          shreg_q <= shreg_q << 8;
          bcnt_q  <= bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(RESP_BYTES-1)) begin
            resp_sent_q <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_state_q  <= TX_IDLE;
          end else begin
            tx_state_q <= TX_LOAD;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;
endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed plus random checks of uart_cmd_framer: serial frames are driven/decoded by the bench
// and compared with words assembled from the byte lists.
module tb_uart_cmd_framer;
  localparam int CPB = 8;
  localparam int CB  = 2;
  localparam int RB  = 2;
  localparam int TMO = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          RX = 1'b1;
  logic          TX;
  logic          clr_cmd_rdy = 1'b0;
  logic [8*CB-1:0] cmd;
  logic          cmd_rdy, frame_err, overrun, tx_busy, resp_sent;
  logic          send_resp = 1'b0;
  logic [8*RB-1:0] resp = '0;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0, ov_cnt = 0, rs_cnt = 0;
  logic busy_at_sent = 1'b1;
  logic [7:0] txq[$];

  uart_cmd_framer #(.CMD_BYTES(CB), .RESP_BYTES(RB), .TIMEOUT_CYC(TMO), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd),
    .cmd_rdy(cmd_rdy), .frame_err(frame_err), .overrun(overrun), .send_resp(send_resp),
    .resp(resp), .tx_busy(tx_busy), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (resp_sent) begin
      rs_cnt++;
      busy_at_sent = tx_busy;
    end
  end

  // Independent 8N1 decoder of the TX line.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge TX);
      repeat (CPB/2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        b[i] = TX;
      end
      repeat (CPB) @(posedge clk);
      txq.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RX = fr[i];
      repeat (CPB-1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 64'(cmd_rdy), 64'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    logic [63:0] exp;
    exp = (64'(b0) << 8) | 64'(b1);
    send_byte(b0);
    send_byte(b1);
    wait_rdy(tag);
    check({tag, "_cmd"}, 64'(cmd), exp);
    $display("frame %s bytes=%02h %02h cmd=%04h", tag, b0, b1, cmd);
    pulse_clr();
    check({tag, "_clr"}, 64'(cmd_rdy), 64'd0);
  endtask

  task automatic do_resp(input string tag, input logic [8*RB-1:0] r, input bit interfere);
    int n = 0;
    int rs0;
    txq.delete();
    rs0 = rs_cnt;
    @(negedge clk);
    resp = r;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    resp = '0;
    check({tag, "_busy"}, 64'(tx_busy), 64'd1);
    if (interfere) begin
      repeat (40) @(negedge clk);
      resp = 16'h1234;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
    end
    while (rs_cnt == rs0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (150) @(negedge clk);
    check({tag, "_sent_cnt"}, 64'(rs_cnt - rs0), 64'd1);
    check({tag, "_busy_at_sent"}, 64'(busy_at_sent), 64'd0);
    check({tag, "_nbytes"}, 64'(txq.size()), 64'(RB));
    for (int i = 0; i < RB; i++) begin
      logic [7:0] got;
      got = (i < txq.size()) ? txq[i] : 8'hxx;
      check({tag, "_byte"}, 64'(got), 64'(r[8*(RB-1-i) +: 8]));
    end
    $display("resp %s word=%04h bytes_seen=%0d", tag, r, txq.size());
  endtask

  initial begin
    int fe0, ov0, n;
    repeat (4) @(negedge clk);
    check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_tx_busy", 64'(tx_busy), 64'd0);
    check("rst_resp_sent", 64'(resp_sent), 64'd0);
    check("rst_TX", 64'(TX), 64'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_frame("a53c", 8'hA5, 8'h3C);
    for (int k = 0; k < 4; k++) do_frame("rand", 8'($urandom), 8'($urandom));

    fe0 = fe_cnt;
    send_byte(8'h11);
    n = 0;
    while (fe_cnt == fe0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_frame_err", 64'(fe_cnt - fe0), 64'd1);
    check("tmo_cmd_rdy", 64'(cmd_rdy), 64'd0);
    $display("timeout after %0d cycles", n);
    do_frame("after_tmo", 8'h22, 8'h33);

    send_byte(8'hBE);
    send_byte(8'hEF);
    wait_rdy("beef");
    ov0 = ov_cnt;
    send_byte(8'h55);
    repeat (20) @(negedge clk);
    check("ovr_pulse", 64'(ov_cnt - ov0), 64'd1);
    check("ovr_cmd", 64'(cmd), 64'hBEEF);
    check("ovr_cmd_rdy", 64'(cmd_rdy), 64'd1);
    $display("overrun byte=55 cmd=%04h", cmd);
    pulse_clr();
    do_frame("0102", 8'h01, 8'h02);

    do_resp("c0de", 16'hC0DE, 1'b0);
    do_resp("c0de_busy", 16'hC0DE, 1'b1);
    for (int k = 0; k < 3; k++) do_resp("rand", 16'($urandom), 1'b0);

    send_byte(8'h77);
    @(negedge clk);
    resp = 16'hC0DE;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_busy", 64'(tx_busy), 64'd0);
    check("mid_rst_TX", 64'(TX), 64'd1);
    check("mid_rst_cmd", 64'(cmd), 64'd0);
    check("mid_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    $display("reset asserted mid-frame and mid-response");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    check("post_rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    do_frame("post_rst", 8'($urandom), 8'($urandom));
    do_resp("post_rst", 16'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
